// File: rtl/pc_gen_if.sv
// Bundle between the PC generator, the hazard/branch control and instruction fetch.
// master = PC generator side, slave = the surrounding pipeline.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            halt_req;
  logic            resume;
  logic            is_compressed;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            fetch_valid;
  logic            misaligned_exc;
  logic [XLEN-1:0] misaligned_addr;
  logic            halted;

  modport master (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           halt_req, resume, is_compressed, fetch_ready,
    output pc, pc_plus, fetch_valid, misaligned_exc, misaligned_addr, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_target, trap_valid, trap_vector,
           halt_req, resume, is_compressed, fetch_ready,
    input  pc, pc_plus, fetch_valid, misaligned_exc, misaligned_addr, halted
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Program-counter generator: architectural PC register, next-PC selection
// (sequential / redirect / trap), stall and halt control, alignment check,
// and a valid/ready presentation of the PC to instruction fetch.
module pc_gen_unit #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          C_EXT        = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  pc_gen_if.master  bus
);

  localparam logic [XLEN-1:0] RV_EXT = XLEN'(RESET_VECTOR);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_exc, w_exc_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;

  logic [XLEN-1:0] w_inc;
  logic [XLEN-1:0] w_pc_plus;
  logic            w_misaligned;
  logic            w_advance;

  // Increment is 2 only for compressed instructions when the C extension exists.
  assign w_inc     = (C_EXT && bus.is_compressed) ? XLEN'(2) : XLEN'(4);
  // Plain modulo-2^XLEN add: the top of the address space wraps to zero.
  assign w_pc_plus = r_pc + w_inc;

  // Redirect targets must be halfword aligned with C, word aligned without.
  // Trap vectors come from trusted CSR state and are not checked.
  assign w_misaligned = C_EXT ? bus.redirect_target[0]
                              : (bus.redirect_target[1:0] != 2'b00);

  // A PC is consumed only when it was actually offered and accepted.
  assign w_advance = (r_state == ST_RUN) && bus.fetch_ready && !bus.stall;

  // State, PC and exception registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RV_EXT;
      r_exc   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_exc   <= w_exc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_exc_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    unique case (r_state)
      ST_BOOT: begin
        // One dead cycle after reset; inputs are not looked at.
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.trap_valid) begin
          w_pc_nxt = bus.trap_vector;
        end else if (bus.redirect_valid && !w_misaligned) begin
          // Control flow change beats stall and backpressure.
          w_pc_nxt = bus.redirect_target;
        end else if (bus.redirect_valid) begin
          w_exc_nxt  = 1'b1;
          w_addr_nxt = bus.redirect_target;
        end else if (w_advance && !bus.halt_req) begin
          w_pc_nxt = w_pc_plus;
        end
        // Trap entry wins over a halt request in the same cycle.
        if (bus.halt_req && !bus.trap_valid)
          w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        // Redirects and stall are ignored; only a trap or resume leave HALT.
        if (bus.trap_valid) begin
          w_pc_nxt    = bus.trap_vector;
          w_state_nxt = ST_RUN;
        end else if (bus.resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RV_EXT;
      end
    endcase
  end

  assign bus.pc              = r_pc;
  assign bus.pc_plus         = w_pc_plus;
  assign bus.fetch_valid     = (r_state == ST_RUN);
  assign bus.halted          = (r_state == ST_HALT);
  assign bus.misaligned_exc  = r_exc;
  assign bus.misaligned_addr = r_addr;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit. Three instances cover XLEN=32 without C,
// XLEN=32 with C, and XLEN=64. Each stimulus cycle pushes the expected
// post-edge outputs; a monitor pops and compares them on the falling edge.
module tb_pc_gen_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;

  // Shared stimulus, fanned out to every instance.
  logic        stall, rv, tv, hr, res, comp, fr;
  logic [63:0] rt, tvec;

  pc_gen_if #(.XLEN(32)) if0 ();
  pc_gen_if #(.XLEN(32)) if1 ();
  pc_gen_if #(.XLEN(64)) if2 ();

  assign if0.stall = stall;           assign if1.stall = stall;           assign if2.stall = stall;
  assign if0.redirect_valid = rv;     assign if1.redirect_valid = rv;     assign if2.redirect_valid = rv;
  assign if0.redirect_target = rt[31:0];
  assign if1.redirect_target = rt[31:0];
  assign if2.redirect_target = rt;
  assign if0.trap_valid = tv;         assign if1.trap_valid = tv;         assign if2.trap_valid = tv;
  assign if0.trap_vector = tvec[31:0];
  assign if1.trap_vector = tvec[31:0];
  assign if2.trap_vector = tvec;
  assign if0.halt_req = hr;           assign if1.halt_req = hr;           assign if2.halt_req = hr;
  assign if0.resume = res;            assign if1.resume = res;            assign if2.resume = res;
  assign if0.is_compressed = comp;    assign if1.is_compressed = comp;    assign if2.is_compressed = comp;
  assign if0.fetch_ready = fr;        assign if1.fetch_ready = fr;        assign if2.fetch_ready = fr;

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .C_EXT(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0));
  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .C_EXT(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1));
  pc_gen_unit #(.XLEN(64), .RESET_VECTOR(32'h8000_0000), .C_EXT(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .bus(if2));

  typedef struct {
    int          id;
    string       name;
    logic [63:0] pc;
    logic [63:0] pc_plus;
    logic        fv;
    logic        halted;
    logic        exc;
    logic [63:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic idle();
    stall = 1'b0; rv = 1'b0; tv = 1'b0; hr = 1'b0; res = 1'b0;
    comp = 1'b0; fr = 1'b1; rt = '0; tvec = '0;
  endtask

  // Clock one edge with the current inputs and queue the expected outputs.
  task automatic step(input int id, input string nm, input logic [63:0] epc,
                      input logic efv, input logic eh, input logic eexc,
                      input logic [63:0] eaddr);
    exp_t e;
    logic [63:0] inc;
    inc = (id == 1 && comp) ? 64'd2 : 64'd4;
    e.id = id; e.name = nm; e.pc = epc; e.fv = efv; e.halted = eh;
    e.exc = eexc; e.addr = eaddr;
    e.pc_plus = (id == 2) ? (epc + inc) : {32'h0, epc[31:0] + inc[31:0]};
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input string fld, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents new outputs every cycle; compare on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] apc, app, aaddr;
      logic afv, ah, aexc;
      e = q.pop_front();
      case (e.id)
        0: begin apc = {32'h0, if0.pc}; app = {32'h0, if0.pc_plus}; aaddr = {32'h0, if0.misaligned_addr};
                 afv = if0.fetch_valid; ah = if0.halted; aexc = if0.misaligned_exc; end
        1: begin apc = {32'h0, if1.pc}; app = {32'h0, if1.pc_plus}; aaddr = {32'h0, if1.misaligned_addr};
                 afv = if1.fetch_valid; ah = if1.halted; aexc = if1.misaligned_exc; end
        default: begin apc = if2.pc; app = if2.pc_plus; aaddr = if2.misaligned_addr;
                 afv = if2.fetch_valid; ah = if2.halted; aexc = if2.misaligned_exc; end
      endcase
      chk(e.name, "pc", apc, e.pc);
      chk(e.name, "pc_plus", app, e.pc_plus);
      chk(e.name, "fetch_valid", {63'h0, afv}, {63'h0, e.fv});
      chk(e.name, "halted", {63'h0, ah}, {63'h0, e.halted});
      chk(e.name, "misaligned_exc", {63'h0, aexc}, {63'h0, e.exc});
      chk(e.name, "misaligned_addr", aaddr, e.addr);
    end
  end

  initial begin
    idle();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    // ---- instance 0: XLEN=32, C_EXT=0, reset vector 0x100 ----
    step(0, "rst_a",  64'h100, 0, 0, 0, 64'h0);
    step(0, "rst_b",  64'h100, 0, 0, 0, 64'h0);
    rst0 = 1'b0;
    step(0, "boot",   64'h100, 1, 0, 0, 64'h0);
    step(0, "seq1",   64'h104, 1, 0, 0, 64'h0);
    step(0, "seq2",   64'h108, 1, 0, 0, 64'h0);
    stall = 1;  step(0, "stall1", 64'h108, 1, 0, 0, 64'h0);
                step(0, "stall2", 64'h108, 1, 0, 0, 64'h0);
    idle(); fr = 0; step(0, "bp",   64'h108, 1, 0, 0, 64'h0);
    idle();     step(0, "seq3",   64'h10C, 1, 0, 0, 64'h0);
    tv = 1; tvec = 64'h800; rv = 1; rt = 64'h200; stall = 1;
                step(0, "prio_trap", 64'h800, 1, 0, 0, 64'h0);
    idle(); rv = 1; rt = 64'h200; stall = 1;
                step(0, "redir_stall", 64'h200, 1, 0, 0, 64'h0);
    idle(); rv = 1; rt = 64'h202;
                step(0, "misalign", 64'h200, 1, 0, 1, 64'h202);
    idle(); stall = 1;
                step(0, "exc_pulse", 64'h200, 1, 0, 0, 64'h202);
    idle(); rv = 1; rt = 64'hFFFF_FFFC;
                step(0, "redir_top", 64'hFFFF_FFFC, 1, 0, 0, 64'h202);
    idle(); hr = 1; tv = 1; tvec = 64'h700;
                step(0, "trap_vs_halt", 64'h700, 1, 0, 0, 64'h202);
    idle(); rv = 1; rt = 64'hFFFF_FFFC;
                step(0, "redir_top2", 64'hFFFF_FFFC, 1, 0, 0, 64'h202);
    idle(); hr = 1;
                step(0, "halt", 64'hFFFF_FFFC, 0, 1, 0, 64'h202);
    idle(); rv = 1; rt = 64'h400; stall = 1;
                step(0, "halt_ignore", 64'hFFFF_FFFC, 0, 1, 0, 64'h202);
    idle(); res = 1;
                step(0, "resume", 64'hFFFF_FFFC, 1, 0, 0, 64'h202);
    idle();     step(0, "wrap", 64'h0, 1, 0, 0, 64'h202);
    idle(); rv = 1; rt = 64'h10; hr = 1;
                step(0, "redir_halt", 64'h10, 0, 1, 0, 64'h202);
    idle(); tv = 1; tvec = 64'h900;
                step(0, "halt_trap", 64'h900, 1, 0, 0, 64'h202);
    idle(); rv = 1; rt = 64'h3;
                step(0, "misalign2", 64'h900, 1, 0, 1, 64'h3);
    idle(); hr = 1;
                step(0, "halt2", 64'h900, 0, 1, 0, 64'h3);
    idle(); rst0 = 1'b1;
                step(0, "rst_mid", 64'h100, 0, 0, 0, 64'h0);

    // ---- instance 1: XLEN=32, C_EXT=1 ----
    idle();
    step(1, "c_rst",  64'h100, 0, 0, 0, 64'h0);
    rst1 = 1'b0;
    step(1, "c_boot", 64'h100, 1, 0, 0, 64'h0);
    rv = 1; rt = 64'h200; step(1, "c_redir", 64'h200, 1, 0, 0, 64'h0);
    idle(); rv = 1; rt = 64'h202; comp = 1;
                step(1, "c_half", 64'h202, 1, 0, 0, 64'h0);
    idle(); comp = 1;
                step(1, "c_inc2", 64'h204, 1, 0, 0, 64'h0);
    idle();     step(1, "c_inc4", 64'h208, 1, 0, 0, 64'h0);
    idle(); rv = 1; rt = 64'h301;
                step(1, "c_misalign", 64'h208, 1, 0, 1, 64'h301);
    idle(); stall = 1;
                step(1, "c_pulse", 64'h208, 1, 0, 0, 64'h301);

    // ---- instance 2: XLEN=64, reset vector 0x8000_0000 ----
    idle();
    step(2, "w_rst",  64'h0000_0000_8000_0000, 0, 0, 0, 64'h0);
    rst2 = 1'b0;
    step(2, "w_boot", 64'h0000_0000_8000_0000, 1, 0, 0, 64'h0);
    step(2, "w_seq",  64'h0000_0000_8000_0004, 1, 0, 0, 64'h0);
    rv = 1; rt = 64'hFFFF_FFFF_FFFF_FFFC;
    step(2, "w_top",  64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 64'h0);
    idle();
    step(2, "w_wrap", 64'h0, 1, 0, 0, 64'h0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
